// File: rtl/pcd_from_picc_rx.sv
// ISO14443A PCD-side receiver: slices PICC load-modulation samples into half-bits and
// decodes Manchester SOF / data / odd parity / EOF into an AXI-Stream byte stream.
module pcd_from_picc_rx #(
  parameter int HALF_BIT = 64,
  parameter int MOD_MIN  = 32,
  parameter int THRESH   = 2048
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        s00_axis_tvalid,
  input  logic [31:0] s00_axis_tdata,
  output logic        s00_axis_tready,
  input  logic        m00_axis_tready,
  output logic        m00_axis_tvalid,
  output logic [7:0]  m00_axis_tdata,
  output logic        m00_axis_tlast,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        err_out,
  output logic [1:0]  err_code_out,
  output logic        overflow_out
);
  localparam int CW = $clog2(HALF_BIT + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SOF1    = 3'd1,
    SOF2    = 3'd2,
    DATA_H1 = 3'd3,
    DATA_H2 = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] win_cnt_r, act_cnt_r, act_sum_s;
  logic [3:0]    bit_cnt_r;
  logic [7:0]    shift_r, held_r;
  logic          held_vld_r, h1_r;
  logic [31:0]   abs_s;
  logic          active_s, last_s, mod_s, pair_end_s, bit_ev_s, coll_s, eof_s;
  logic          par_ev_s, byte_ok_s, par_err_s, trunc_s, abort_s;
  logic          push_s, push_last_s, done_s, err_s;
  logic [1:0]    err_code_s;
  logic          ready_r, busy_r, done_r, err_r, ovf_r, tvalid_r, tlast_r;
  logic [7:0]    tdata_r;
  logic [1:0]    err_code_r;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Sample magnitude, window end detection and half-bit pair classification.
  always_comb begin
    if (s00_axis_tdata == 32'h8000_0000) begin
      abs_s = 32'h7FFF_FFFF;
    end else if (s00_axis_tdata[31]) begin
      abs_s = 32'd0 - s00_axis_tdata;
    end else begin
      abs_s = s00_axis_tdata;
    end
    active_s   = (abs_s >= 32'(THRESH));
    act_sum_s  = act_cnt_r + CW'(active_s);
    last_s     = s00_axis_tvalid && (state_r != IDLE) && (win_cnt_r == CW'(HALF_BIT - 1));
    mod_s      = (act_sum_s >= CW'(MOD_MIN));
    pair_end_s = last_s && (state_r == DATA_H2);
    bit_ev_s   = pair_end_s && (h1_r != mod_s);
    coll_s     = pair_end_s && h1_r && mod_s;
    eof_s      = pair_end_s && !h1_r && !mod_s;
    par_ev_s   = bit_ev_s && (bit_cnt_r == 4'd8);
    byte_ok_s  = par_ev_s && odd_parity_ok(shift_r, h1_r);
    par_err_s  = par_ev_s && !odd_parity_ok(shift_r, h1_r);
    trunc_s    = eof_s && (bit_cnt_r != 4'd0);
    abort_s    = coll_s || par_err_s || trunc_s;
  end

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (s00_axis_tvalid && active_s) state_s = SOF1; else state_s = IDLE;
      SOF1:    if (last_s && mod_s) state_s = SOF2; else if (last_s) state_s = IDLE; else state_s = SOF1;
      SOF2:    if (last_s && mod_s) state_s = IDLE; else if (last_s) state_s = DATA_H1; else state_s = SOF2;
      DATA_H1: if (last_s) state_s = DATA_H2; else state_s = DATA_H1;
      DATA_H2: begin
        if (last_s && (abort_s || eof_s)) begin
          state_s = IDLE;
        end else if (last_s) begin
          state_s = DATA_H1;
        end else begin
          state_s = DATA_H2;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decisions: the held byte goes out one byte late so tlast is known.
  always_comb begin
    done_s = eof_s && !trunc_s;
    err_s  = abort_s;
    if (held_vld_r && byte_ok_s) begin
      push_s      = 1'b1;
      push_last_s = 1'b0;
    end else if (held_vld_r && (eof_s || abort_s)) begin
      push_s      = 1'b1;
      push_last_s = 1'b1;
    end else begin
      push_s      = 1'b0;
      push_last_s = 1'b0;
    end
    if (coll_s) begin
      err_code_s = 2'd2;
    end else if (par_err_s) begin
      err_code_s = 2'd1;
    end else if (trunc_s) begin
      err_code_s = 2'd3;
    end else begin
      err_code_s = 2'd0;
    end
  end

  // Half-bit window counters; a frame's first active sample is window sample 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      win_cnt_r <= '0;
      act_cnt_r <= '0;
    end else if (s00_axis_tvalid && (state_r == IDLE) && active_s) begin
      win_cnt_r <= CW'(1);
      act_cnt_r <= CW'(1);
    end else if (last_s) begin
      win_cnt_r <= '0;
      act_cnt_r <= '0;
    end else if (s00_axis_tvalid && (state_r != IDLE)) begin
      win_cnt_r <= win_cnt_r + CW'(1);
      act_cnt_r <= act_sum_s;
    end
  end

  // Bit assembly, parity and the holding register.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'd0;
      held_r     <= 8'd0;
      held_vld_r <= 1'b0;
      h1_r       <= 1'b0;
    end else if (last_s) begin
      case (state_r)
        SOF2:    bit_cnt_r <= 4'd0;
        DATA_H1: h1_r <= mod_s;
        DATA_H2: begin
          if (par_ev_s) begin
            bit_cnt_r <= 4'd0;
            if (byte_ok_s) begin
              held_r     <= shift_r;
              held_vld_r <= 1'b1;
            end
          end else if (bit_ev_s) begin
            shift_r   <= {h1_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
          if (eof_s || abort_s) held_vld_r <= 1'b0;
        end
        default: bit_cnt_r <= bit_cnt_r;
      endcase
    end
  end

  // Output stage and status flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      err_code_r <= 2'd0;
      ovf_r      <= 1'b0;
      tvalid_r   <= 1'b0;
      tdata_r    <= 8'd0;
      tlast_r    <= 1'b0;
    end else begin
      ready_r <= 1'b1;
      busy_r  <= (state_s != IDLE);
      done_r  <= done_s;
      err_r   <= err_s;
      if (err_s) err_code_r <= err_code_s;
      if (push_s && tvalid_r && !m00_axis_tready) begin
        ovf_r <= 1'b1;
      end else if (push_s) begin
        tvalid_r <= 1'b1;
        tdata_r  <= held_r;
        tlast_r  <= push_last_s;
      end else if (tvalid_r && m00_axis_tready) begin
        tvalid_r <= 1'b0;
      end
    end
  end

  assign s00_axis_tready = ready_r;
  assign m00_axis_tvalid = tvalid_r;
  assign m00_axis_tdata  = tdata_r;
  assign m00_axis_tlast  = tlast_r;
  assign busy_out        = busy_r;
  assign frame_done_out  = done_r;
  assign err_out         = err_r;
  assign err_code_out    = err_code_r;
  assign overflow_out    = ovf_r;
endmodule

// File: tb/tb_pcd_from_picc_rx.sv
// Scoreboard bench for pcd_from_picc_rx: synthesises Manchester half-bits as sample
// streams, models the expected byte stream and compares it at each output handshake.
module tb_pcd_from_picc_rx;
  localparam int HB = 64;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        s00_axis_tvalid = 1'b0;
  logic [31:0] s00_axis_tdata = 32'd0;
  logic        s00_axis_tready;
  logic        m00_axis_tready = 1'b1;
  logic        m00_axis_tvalid;
  logic [7:0]  m00_axis_tdata;
  logic        m00_axis_tlast;
  logic        busy_out, frame_done_out, err_out, overflow_out;
  logic [1:0]  err_code_out;

  pcd_from_picc_rx #(.HALF_BIT(HB), .MOD_MIN(32), .THRESH(2048)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s00_axis_tvalid(s00_axis_tvalid), .s00_axis_tdata(s00_axis_tdata),
    .s00_axis_tready(s00_axis_tready), .m00_axis_tready(m00_axis_tready),
    .m00_axis_tvalid(m00_axis_tvalid), .m00_axis_tdata(m00_axis_tdata),
    .m00_axis_tlast(m00_axis_tlast), .busy_out(busy_out),
    .frame_done_out(frame_done_out), .err_out(err_out),
    .err_code_out(err_code_out), .overflow_out(overflow_out)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_pass = 0;
  int err_cnt = 0, done_cnt = 0, byte_cnt = 0, act_cyc = 0;
  logic [1:0] last_code = 2'd0;
  logic [8:0] exp_q[$];
  logic       gaps = 1'b0, model_on = 1'b1, held_vld = 1'b0;
  logic [7:0] held = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] outs();
    return {s00_axis_tready, m00_axis_tvalid, m00_axis_tdata, m00_axis_tlast,
            busy_out, frame_done_out, err_out, err_code_out, overflow_out};
  endfunction

  // Monitor on the falling edge: count pulses and score every completed handshake.
  always @(negedge clk_in) begin
    logic [8:0] e;
    if (!rst_in) begin
      if (err_out) begin err_cnt++; last_code = err_code_out; end
      if (frame_done_out) done_cnt++;
      if (m00_axis_tvalid || busy_out || err_out || frame_done_out) act_cyc++;
      if (m00_axis_tvalid && m00_axis_tready) begin
        byte_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("byte", {23'd0, m00_axis_tlast, m00_axis_tdata}, {23'd0, e});
        end
      end
    end
  end

  task automatic drive(input logic [31:0] v);
    if (gaps) begin
      s00_axis_tvalid = 1'b0;
      s00_axis_tdata  = 32'd5000;
      @(posedge clk_in); #1;
    end
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata  = v;
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive((i % 2 == 0) ? 32'd100 : -32'sd100);
  endtask

  // Last n_act samples of the half are active at amp_on; the rest sit at amp_off.
  task automatic send_half(input int n_act, input int amp_on, input int amp_off);
    int a;
    for (int i = 0; i < HB; i++) begin
      a = (i >= HB - n_act) ? amp_on : amp_off;
      if (n_act == HB && i == 1) drive(32'h8000_0000);
      else drive((i % 2 == 0) ? 32'(a) : 32'(-a));
    end
  endtask

  task automatic send_bit(input logic b);
    if (b) begin send_half(HB, 4000, 100); send_half(0, 4000, 100); end
    else   begin send_half(0, 4000, 100);  send_half(HB, 4000, 100); end
  endtask

  task automatic model_close();
    if (model_on && held_vld) exp_q.push_back({1'b1, held});
    held_vld = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] d, input logic p);
    if (^{d, p}) begin
      if (model_on && held_vld) exp_q.push_back({1'b0, held});
      held = d;
      held_vld = 1'b1;
    end else begin
      model_close();
    end
  endtask

  task automatic send_sof();
    send_half(HB, 4000, 100);
    send_half(0, 4000, 100);
  endtask

  task automatic send_eof();
    model_close();
    send_half(0, 4000, 100);
    send_half(0, 4000, 100);
  endtask

  // edge0 sends a 0 bit whose halves sit exactly on the THRESH / MOD_MIN boundaries.
  task automatic send_byte(input logic [7:0] d, input logic p, input logic edge0);
    model_byte(d, p);
    for (int i = 0; i < 8; i++) begin
      if (edge0 && i == 0) begin
        send_half(31, 2048, 2047);
        send_half(32, 2048, 2047);
      end else begin
        send_bit(d[i]);
      end
    end
    send_bit(p);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk_in); #1;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, b0, a0;
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_outs", 32'(outs()), 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    check_eq("s_tready", 32'(s00_axis_tready), 32'd1);

    // 1: idle noise below threshold
    a0 = act_cyc; e0 = err_cnt;
    idle(10000);
    check_eq("noise_activity", 32'(act_cyc - a0), 32'd0);
    check_eq("noise_err", 32'(err_cnt - e0), 32'd0);

    // 2: good two-byte frame, first bit on the slicing boundaries
    e0 = err_cnt; d0 = done_cnt; b0 = byte_cnt;
    send_sof(); send_byte(8'h24, 1'b1, 1'b1); send_byte(8'h90, 1'b1, 1'b0); send_eof();
    idle(20); drain();
    check_eq("f2_done", 32'(done_cnt - d0), 32'd1);
    check_eq("f2_bytes", 32'(byte_cnt - b0), 32'd2);
    check_eq("f2_err", 32'(err_cnt - e0), 32'd0);

    // 3: parity error on the only byte
    e0 = err_cnt; b0 = byte_cnt;
    send_sof(); send_byte(8'h35, 1'b0, 1'b0);
    idle(20); drain();
    check_eq("par_err", 32'(err_cnt - e0), 32'd1);
    check_eq("par_code", 32'(last_code), 32'd1);
    check_eq("par_bytes", 32'(byte_cnt - b0), 32'd0);
    check_eq("par_busy", 32'(busy_out), 32'd0);

    // 4: collision after three bits
    e0 = err_cnt; b0 = byte_cnt;
    send_sof(); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); model_close();
    send_half(HB, 4000, 100); send_half(HB, 4000, 100);
    idle(20); drain();
    check_eq("coll_err", 32'(err_cnt - e0), 32'd1);
    check_eq("coll_code", 32'(err_code_out), 32'd2);
    check_eq("coll_tvalid", 32'(m00_axis_tvalid), 32'd0);
    check_eq("coll_bytes", 32'(byte_cnt - b0), 32'd0);

    // 4b: truncated byte flushes the held byte with tlast; empty frame
    e0 = err_cnt; d0 = done_cnt;
    send_sof(); send_byte(8'h5A, 1'b1, 1'b0); send_bit(1'b1); send_bit(1'b0); send_eof();
    idle(20); drain();
    check_eq("trunc_code", 32'(last_code), 32'd3);
    check_eq("trunc_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt; b0 = byte_cnt;
    send_sof(); send_eof();
    idle(20);
    check_eq("empty_done", 32'(done_cnt - d0), 32'd1);
    check_eq("empty_bytes", 32'(byte_cnt - b0), 32'd0);
    check_eq("trunc_err_total", 32'(err_cnt - e0), 32'd1);

    // 5: backpressure, later bytes dropped
    m00_axis_tready = 1'b0; model_on = 1'b0; d0 = done_cnt;
    send_sof(); send_byte(8'h24, 1'b1, 1'b0); send_byte(8'h90, 1'b1, 1'b0);
    send_byte(8'h67, 1'b0, 1'b0); send_eof();
    idle(20);
    check_eq("bp_tvalid", 32'(m00_axis_tvalid), 32'd1);
    check_eq("bp_tdata", 32'(m00_axis_tdata), 32'h24);
    check_eq("bp_tlast", 32'(m00_axis_tlast), 32'd0);
    check_eq("bp_overflow", 32'(overflow_out), 32'd1);
    check_eq("bp_done", 32'(done_cnt - d0), 32'd1);

    // 6a: reset in the middle of a byte
    e0 = err_cnt;
    send_sof(); send_bit(1'b0); send_bit(1'b0);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    check_eq("midrst_outs", 32'(outs()), 32'd0);
    rst_in = 1'b0; s00_axis_tvalid = 1'b0;
    exp_q.delete(); held_vld = 1'b0;
    @(posedge clk_in); #1;
    check_eq("midrst_ready", 32'(s00_axis_tready), 32'd1);
    check_eq("midrst_err", 32'(err_cnt - e0), 32'd0);

    // 6b: same frame as test 2 with an invalid cycle between every sample
    m00_axis_tready = 1'b1; model_on = 1'b1; gaps = 1'b1;
    d0 = done_cnt; b0 = byte_cnt;
    send_sof(); send_byte(8'h24, 1'b1, 1'b0); send_byte(8'h90, 1'b1, 1'b0); send_eof();
    idle(20); drain();
    check_eq("gap_done", 32'(done_cnt - d0), 32'd1);
    check_eq("gap_bytes", 32'(byte_cnt - b0), 32'd2);
    check_eq("gap_overflow", 32'(overflow_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
